// File: rtl/res_buffer.sv
// Residual-path FIFO: stores block-input feature vectors and replays them in order,
// registered, so bn_res sees a stable residual in the cycle it adds it to its product.
module res_buffer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int FM_DEPTH   = 64,
    parameter  int BUF_DEPTH  = 8,
    localparam int ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 clr_i,
    input  logic                                 wr_valid_i,
    input  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0]  wr_data_i,
    output logic                                 wr_ready_o,
    input  logic                                 rd_en_i,
    output logic [FM_DEPTH-1:0][DATA_WIDTH-1:0]  res_o,
    output logic                                 res_valid_o,
    output logic [ADDR_WIDTH:0]                  count_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic                                 ovf_err_o,
    output logic                                 unf_err_o
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

    logic [ADDR_WIDTH-1:0]               wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]               rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]                 count_q, count_d;
    logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] res_q, res_d;
    logic                                res_valid_q, res_valid_d;
    logic                                ovf_q, ovf_d;
    logic                                unf_q, unf_d;

    logic full, empty, wr_ready, do_wr, do_rd;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign wr_ready = ~full | rd_en_i;
    assign do_wr    = wr_valid_i & wr_ready & ~clr_i;
    assign do_rd    = rd_en_i & ~empty & ~clr_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (wr_valid_i) begin
                ovf_d = 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                res_d       = mem_q[rd_ptr_q];
                res_valid_d = 1'b1;
            end else if (rd_en_i) begin
                unf_d = 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is deliberately left out of reset; only pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign wr_ready_o  = wr_ready;
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign ovf_err_o   = ovf_q;
    assign unf_err_o   = unf_q;

endmodule
